code_stepper: RTL and testbench

Upstream stage for the 3-to-8 one-hot decoder. Debounces a raw push-key and, on each accepted press, advances a 3-bit code 000→111→000. An optional auto-run mode also steps the code at a fixed period. Outputs `out1`/`out2`/`out3` drive the decoder inputs `in1`/`in2`/`in3` directly; `{out1,out2,out3}` is the code, MSB first.

---
 rtl/code_stepper.sv | 155 +++++++++++++++
 tb/tb_code_stepper.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/code_stepper.sv
// code_stepper: debounced push-key stepper feeding a 3-to-8 one-hot decoder.
//
// Each accepted key press advances a 3-bit code 000->111->000. Optional
// auto-run mode also steps the code every CNT_AUTO cycles.
//
// Optional feature macro: CODE_STEPPER_AUTO_RUN_EN
//   defined   -> auto timer and mode_in synchroniser are built
//   undefined -> mode_in is ignored; only key steps advance the code
//
// Ports:
//   sys_clk     in   single clock, rising edge
//   sys_rst     in   synchronous active-high reset
//   key_in      in   raw push-key, active-low, asynchronous
//   mode_in     in   slide switch, asynchronous; 1 = auto-run
//   out1        out  code bit 2 (MSB)
//   out2        out  code bit 1
//   out3        out  code bit 0
//   step_pulse  out  one-cycle strobe, high in the cycle a new code appears
//
// Parameters:
//   CNT_DEBOUNCE  stable-level cycles to accept press/release (>= 2)
//   CNT_AUTO      auto-run step period in cycles (>= 2)

module code_stepper #(
  parameter int unsigned CNT_DEBOUNCE = 1_000_000,
  parameter int unsigned CNT_AUTO     = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  input  logic mode_in,
  output logic out1,
  output logic out2,
  output logic out3,
  output logic step_pulse
);

  localparam int DW = $clog2(CNT_DEBOUNCE);
  localparam logic [DW-1:0] CNT_LAST = DW'(CNT_DEBOUNCE - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t          state;
  logic [DW-1:0]   cnt;
  logic [2:0]      code;
  logic [1:0]      key_sync;
  logic            key_s;
  logic            key_step;
  logic            auto_step;
  logic            step;

  // Key synchroniser resets to the released level so reset never looks like
  // a press; a key held through reset release still needs a full debounce.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) key_sync <= 2'b11;
    else         key_sync <= {key_sync[0], key_in};
  end
  assign key_s = key_sync[1];

`ifdef CODE_STEPPER_AUTO_RUN_EN
  localparam int AW = $clog2(CNT_AUTO);
  localparam logic [AW-1:0] ACNT_LAST = AW'(CNT_AUTO - 1);

  logic [1:0]    mode_sync;
  logic          mode_s;
  logic [AW-1:0] acnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode_sync <= 2'b00;
      acnt      <= '0;
    end else begin
      mode_sync <= {mode_sync[0], mode_in};
      // Leaving auto mode throws away the partial period.
      if (!mode_s)                acnt <= '0;
      else if (acnt == ACNT_LAST) acnt <= '0;
      else                        acnt <= acnt + AW'(1);
    end
  end
  assign mode_s    = mode_sync[1];
  assign auto_step = mode_s && (acnt == ACNT_LAST);
`else
  logic unused_mode;
  assign unused_mode = mode_in;
  assign auto_step   = 1'b0;
`endif

  // Key step fires on the edge that moves PRESS_WAIT -> HELD.
  assign key_step = (state == PRESS_WAIT) && !key_s && (cnt == CNT_LAST);
  // Coincident key and auto steps merge into a single +1.
  assign step     = key_step | auto_step;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      code       <= 3'd0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= step;
      if (step) code <= code + 3'd1;

      case (state)
        IDLE: begin
          if (!key_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (key_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        HELD: begin
          if (key_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A bounce low just returns to HELD; no step is generated.
          if (!key_s) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign out1 = code[2];
  assign out2 = code[1];
  assign out3 = code[0];

endmodule

// File: tb/tb_code_stepper.sv
// Directed bench for code_stepper with CNT_DEBOUNCE=4, CNT_AUTO=8.
// Auto-run checks are built only when CODE_STEPPER_AUTO_RUN_EN is defined;
// otherwise mode_in is driven high and must be ignored.

module tb_code_stepper;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key_in  = 1'b1;
  logic mode_in = 1'b0;
  logic out1, out2, out3, step_pulse;
  logic [2:0] code_o;

  int n_vec  = 0;
  int n_err  = 0;
  int pulses = 0;
  int base;

  code_stepper #(.CNT_DEBOUNCE(4), .CNT_AUTO(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_in    (key_in),
    .mode_in   (mode_in),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .step_pulse(step_pulse)
  );

  assign code_o = {out1, out2, out3};

  always #5 sys_clk = ~sys_clk;

  // One edge; sample 1ns after it and tally strobes.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (step_pulse === 1'b1) pulses++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    key_in  = 1'b1;
    sys_rst = 1'b1;
    ticks(2);
    sys_rst = 1'b0;
    pulses  = 0;
  endtask

  // Clean press: step lands after E6, then full release debounce.
  task automatic press_clean();
    key_in = 1'b0;
    ticks(10);
    key_in = 1'b1;
    ticks(10);
  endtask

  initial begin
    logic [4:0] bpat;
    logic [3:0] rpat;

    // ---------------- reset ----------------
    mode_in = 1'b0;
    do_reset();
    chk("rst_code", code_o, 3'b000);
    chk("rst_pulse", step_pulse, 1'b0);
    ticks(50);
    chk("idle_code", code_o, 3'b000);
    chk("idle_pulses", pulses, 0);

    // ---------------- clean press ----------------
    key_in = 1'b0;          // first sampled at E0
    ticks(6);               // now after E5
    chk("press_e5_pulse", step_pulse, 1'b0);
    tick();                 // after E6
    chk("press_e6_pulse", step_pulse, 1'b1);
    chk("press_e6_code", code_o, 3'b001);
    tick();                 // after E7
    chk("press_e7_pulse", step_pulse, 1'b0);
    ticks(13);              // held 20 cycles total
    key_in = 1'b1;
    ticks(12);
    chk("press_count", pulses, 1);
    chk("press_rel_code", code_o, 3'b001);

    // ---------------- bounce on press ----------------
    bpat = 5'b10100;        // applied LSB first: 0,0,1,0,1
    for (int i = 0; i < 5; i++) begin
      key_in = bpat[i];
      tick();               // after E0..E4
    end
    key_in = 1'b0;          // steady low from E5
    ticks(6);               // after E10
    chk("bounce_e10_count", pulses, 1);
    tick();                 // after E11
    chk("bounce_e11_pulse", step_pulse, 1'b1);
    chk("bounce_e11_code", code_o, 3'b010);
    ticks(3);
    rpat = 4'b0101;         // release bounce: 1,0,1,0
    for (int i = 0; i < 4; i++) begin
      key_in = rpat[i];
      tick();
    end
    key_in = 1'b1;
    ticks(14);
    chk("rel_bounce_count", pulses, 2);
    chk("rel_bounce_code", code_o, 3'b010);

    // ---------------- wrap ----------------
    do_reset();
    for (int i = 0; i < 8; i++) begin
      press_clean();
      chk($sformatf("wrap_code%0d", i), code_o, 32'((i + 1) % 8));
    end
    chk("wrap_count", pulses, 8);

`ifdef CODE_STEPPER_AUTO_RUN_EN
    // ---------------- auto run ----------------
    mode_in = 1'b0;
    do_reset();
    mode_in = 1'b1;         // first sampled at E0
    ticks(9);               // after E8
    chk("auto_e8_count", pulses, 0);
    tick();                 // after E9
    chk("auto_e9_pulse", step_pulse, 1'b1);
    chk("auto_e9_code", code_o, 3'b001);
    ticks(7);               // after E16
    chk("auto_e16_pulse", step_pulse, 1'b0);
    tick();                 // after E17
    chk("auto_e17_pulse", step_pulse, 1'b1);
    chk("auto_e17_code", code_o, 3'b010);
    ticks(5);               // after E22, acnt = 5
    mode_in = 1'b0;
    ticks(5);               // after E27, timer flushed
    base = pulses;
    mode_in = 1'b1;         // sampled at F0, mode_s rises after F1
    ticks(9);               // after F8
    chk("auto_restart_f8", pulses, base);
    tick();                 // after F9
    chk("auto_restart_pulse", step_pulse, 1'b1);
    chk("auto_restart_code", code_o, 3'b011);
    // Key press timed so its step lands on F17, the next auto step.
    tick();                 // after F10
    key_in = 1'b0;          // key E0 = F11, key E6 = F17
    ticks(7);               // after F17
    chk("coinc_pulse", step_pulse, 1'b1);
    chk("coinc_code", code_o, 3'b100);
    chk("coinc_count", pulses, base + 2);
    tick();
    chk("coinc_after_code", code_o, 3'b100);
    key_in  = 1'b1;
    mode_in = 1'b0;
    ticks(12);
`else
    // ---------------- auto run not built ----------------
    mode_in = 1'b1;
    do_reset();
    ticks(100);
    chk("noauto_count", pulses, 0);
    chk("noauto_code", code_o, 3'b000);
    press_clean();
    chk("noauto_key_code", code_o, 3'b001);
    chk("noauto_key_count", pulses, 1);
    mode_in = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
